hash_lane_merger: RTL and testbench
===================================

HASH_LANE_MERGER -- requirements
Module: hash_lane_merger

Interface
REQ-001 Parameter PART_BITS, default 4, number of low tag bits used as partition index (range 1..8).
REQ-002 Parameter NUM_LANES, default 8, number of hashed input lanes (fixed at 8 in this revision).
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  [7:0]  per-lane tuple valid from hash stage.
REQ-006 Port in_tuple  input  [7:0][63:0]  per-lane tuple.
REQ-007 Port in_tag  input  [7:0][31:0]  per-lane hash tag.
REQ-008 Port ready_4_output  output  [7:0]  per-lane accept, driven to the hash stage's ready_4_output.
REQ-009 Port out_valid  output  1  merged tuple valid.
REQ-010 Port out_tuple  output  [63:0]  merged tuple.
REQ-011 Port out_part_id  output  [PART_BITS-1:0]  partition index of out_tuple.
REQ-012 Port out_lane  output  [2:0]  source lane of out_tuple.
REQ-013 Port out_ready  input  1  downstream accept.
REQ-014 Ports hist_clear (input 1), hist_rd_addr (input [PART_BITS-1:0]), hist_rd_data (output [31:0]); present only under HASH_LANE_HISTOGRAM_EN.

Function
REQ-015 Transfer on lane i occurs when in_valid[i] and ready_4_output[i] are both high at a rising edge; output transfer when out_valid and out_ready both high.
REQ-016 Single output register (one-entry buffer); slot is "free" when out_valid low or out_ready high in the same cycle.
REQ-017 Round-robin pointer rr_ptr (3 bits): grant goes to the first lane with in_valid high searching rr_ptr, rr_ptr+1, ... mod 8.
REQ-018 At most one ready_4_output bit high per cycle: only the granted lane, and only when slot is free; all others low.
REQ-019 ready_4_output depends combinationally on in_valid, rr_ptr, out_valid, out_ready; no dependence of in_valid on ready (AXI-style) assumed.
REQ-020 On a lane transfer, next cycle: out_valid=1, out_tuple=in_tuple[g], out_part_id=in_tag[g][PART_BITS-1:0], out_lane=g; rr_ptr=(g+1) mod 8 (wrap 7->0).
REQ-021 Latency input-to-output exactly 1 cycle; throughput 1 tuple/cycle while out_ready held high.
REQ-022 Output stalled (out_valid high, out_ready low): out_* registers held stable, no lane accepted, rr_ptr unchanged.
REQ-023 Output drained with no lane valid: out_valid falls to 0 next cycle; rr_ptr unchanged.
REQ-024 Lane starvation bound: a continuously valid lane is granted within 8 consecutive output transfers.
REQ-025 Tag bits above PART_BITS ignored; tuple passed unmodified.

Reset
REQ-026 While reset high at a clock edge: out_valid=0, out_tuple=0, out_part_id=0, out_lane=0, rr_ptr=0, ready_4_output=0 (forced low combinationally during reset).
REQ-027 Reset mid-stall discards the buffered tuple; no transfer counted.
REQ-028 Under HASH_LANE_HISTOGRAM_EN, reset clears all counters to 0 and hist_rd_data to 0.

Configuration
REQ-029 Macro HASH_LANE_HISTOGRAM_EN defined: 2^PART_BITS 32-bit counters; counter[out_part_id] increments by 1 on every output transfer; saturates at 0xFFFFFFFF.
REQ-030 hist_rd_data registered: equals counter[hist_rd_addr] sampled at previous edge (1-cycle read latency, pre-increment value).
REQ-031 hist_clear high: all counters 0 next cycle; concurrent increment is dropped (clear wins).
REQ-032 Macro undefined: no counters, hist_* ports absent, merger behaviour identical.

Verification
REQ-033 Reset, then in_valid=8'hFF constant, out_ready=1 -> outputs lane 0,1,...,7,0 on consecutive cycles; first out_valid one cycle after first grant.
REQ-034 in_valid=8'b1000_0001, rr_ptr=1 -> grant lane 7, then lane 0 (wrap), rr_ptr=1 after.
REQ-035 out_ready=0 for 5 cycles with out_valid=1 -> out_tuple stable, ready_4_output=0, no tuple lost; release -> next grant resumes same cycle.
REQ-036 PART_BITS=4, tag 0xDEADBEE7 -> out_part_id=4'h7; with histogram, 3 such transfers -> hist_rd_addr=7 reads 3.
REQ-037 hist_clear asserted in same cycle as transfer to partition 2 -> counter[2]=0 afterwards; counter at 0xFFFFFFFF plus transfer -> stays 0xFFFFFFFF.
REQ-038 reset asserted while out_valid=1 stalled -> out_valid=0 next cycle, rr_ptr=0, lane 0 granted first after release.

Source files
------------

// File: rtl/hash_lane_merger.sv
// Merges 8 hashed lanes into one stream through a one-entry output buffer.
// A round-robin pointer picks the lane. Optional per-partition histogram
// is enabled by HASH_LANE_HISTOGRAM_EN.
module hash_lane_merger #(
  parameter int unsigned PART_BITS = 4,
  parameter int unsigned NUM_LANES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           in_valid,
  input  logic [7:0][63:0]     in_tuple,
  input  logic [7:0][31:0]     in_tag,
  output logic [7:0]           ready_4_output,
  output logic                 out_valid,
  output logic [63:0]          out_tuple,
  output logic [PART_BITS-1:0] out_part_id,
  output logic [2:0]           out_lane,
  input  logic                 out_ready
`ifdef HASH_LANE_HISTOGRAM_EN
  ,
  input  logic                 hist_clear,
  input  logic [PART_BITS-1:0] hist_rd_addr,
  output logic [31:0]          hist_rd_data
`endif
);

  logic                 out_valid_q;
  logic [63:0]          out_tuple_q;
  logic [PART_BITS-1:0] out_part_q;
  logic [2:0]           out_lane_q;
  logic [2:0]           rr_ptr_q;

  logic                 slot_free;
  logic                 grant_found;
  logic [2:0]           grant_lane;
  logic                 accept;

  // Tag bits above the partition field are intentionally ignored.
  logic                 unused_tag;
  assign unused_tag = ^in_tag;

  assign slot_free = !out_valid_q || out_ready;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_lane  = '0;
    for (int k = int'(NUM_LANES) - 1; k >= 0; k--) begin
      if (in_valid[3'(rr_ptr_q + 3'(k))]) begin
        grant_found = 1'b1;
        grant_lane  = 3'(rr_ptr_q + 3'(k));
      end
    end
  end

  always_comb begin
    ready_4_output = '0;
    accept         = 1'b0;
    if (!reset && grant_found && slot_free) begin
      accept                     = 1'b1;
      ready_4_output[grant_lane] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_tuple_q <= '0;
      out_part_q  <= '0;
      out_lane_q  <= '0;
      rr_ptr_q    <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_tuple_q <= in_tuple[grant_lane];
      out_part_q  <= in_tag[grant_lane][PART_BITS-1:0];
      out_lane_q  <= grant_lane;
      rr_ptr_q    <= grant_lane + 3'd1;
    end else if (slot_free) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_tuple   = out_tuple_q;
  assign out_part_id = out_part_q;
  assign out_lane    = out_lane_q;

`ifdef HASH_LANE_HISTOGRAM_EN
  localparam int unsigned NumParts = 1 << PART_BITS;

  logic [31:0] hist_q [NumParts];
  logic [31:0] hist_rd_q;
  logic        out_xfer;

  assign out_xfer = out_valid_q && out_ready;

  // Clear has priority over a concurrent increment; counters saturate.
  always_ff @(posedge clk) begin
    if (reset || hist_clear) begin
      for (int p = 0; p < int'(NumParts); p++) begin
        hist_q[p] <= '0;
      end
    end else if (out_xfer && (hist_q[out_part_q] != 32'hFFFF_FFFF)) begin
      hist_q[out_part_q] <= hist_q[out_part_q] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_rd_q <= '0;
    end else begin
      hist_rd_q <= hist_q[hist_rd_addr];
    end
  end

  assign hist_rd_data = hist_rd_q;
`endif

endmodule

// File: tb/tb_hash_lane_merger.sv
// Randomised and directed checks of hash_lane_merger against a transaction-level
// reference model; histogram checks compile in with HASH_LANE_HISTOGRAM_EN.
module tb_hash_lane_merger;
  localparam int PB = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        in_valid;
  logic [7:0][63:0]  in_tuple;
  logic [7:0][31:0]  in_tag;
  logic [7:0]        ready_4_output;
  logic              out_valid;
  logic [63:0]       out_tuple;
  logic [PB-1:0]     out_part_id;
  logic [2:0]        out_lane;
  logic              out_ready;
`ifdef HASH_LANE_HISTOGRAM_EN
  logic              hist_clear;
  logic [PB-1:0]     hist_rd_addr;
  logic [31:0]       hist_rd_data;
  int                rd_fix = -1;
  int unsigned       m_cnt [1 << PB];
  logic [31:0]       m_rd;
`endif

  always #5 clk = ~clk;

  hash_lane_merger #(.PART_BITS(PB), .NUM_LANES(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_tuple       (in_tuple),
    .in_tag         (in_tag),
    .ready_4_output (ready_4_output),
    .out_valid      (out_valid),
    .out_tuple      (out_tuple),
    .out_part_id    (out_part_id),
    .out_lane       (out_lane),
    .out_ready      (out_ready)
`ifdef HASH_LANE_HISTOGRAM_EN
    ,
    .hist_clear     (hist_clear),
    .hist_rd_addr   (hist_rd_addr),
    .hist_rd_data   (hist_rd_data)
`endif
  );

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] tag_fix = '0;

  // Reference model: the buffered tuple plus the next lane to favour.
  bit          m_valid = 0;
  logic [63:0] m_tuple = '0;
  logic [PB-1:0] m_part = '0;
  int          m_lane = 0;
  int          m_rr   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int grant_of(input logic [7:0] v, input int rr);
    for (int k = 0; k < 8; k++) begin
      if (v[(rr + k) % 8]) return (rr + k) % 8;
    end
    return -1;
  endfunction

  // One clock: randomise lane payloads, check ready before the edge, advance
  // the model across the edge, then check the registered outputs.
  task automatic cycle();
    int          g;
    bit          free;
    logic [7:0]  er;
    logic [63:0] ld_tuple;
    logic [31:0] ld_tag;
    for (int i = 0; i < 8; i++) begin
      in_tuple[i] = {$urandom, $urandom};
      in_tag[i]   = (tag_fix != 0) ? tag_fix : $urandom;
    end
`ifdef HASH_LANE_HISTOGRAM_EN
    hist_rd_addr = (rd_fix >= 0) ? PB'(rd_fix) : PB'($urandom);
`endif
    #1;
    g    = grant_of(in_valid, m_rr);
    free = !m_valid || out_ready;
    er   = '0;
    ld_tuple = '0;
    ld_tag   = '0;
    if (!reset && g >= 0 && free) begin
      er[g]    = 1'b1;
      ld_tuple = in_tuple[g];
      ld_tag   = in_tag[g];
    end
    chk("ready_4_output", 64'(ready_4_output), 64'(er));
    @(posedge clk);
    #1;
`ifdef HASH_LANE_HISTOGRAM_EN
    if (reset) begin
      foreach (m_cnt[p]) m_cnt[p] = 0;
      m_rd = '0;
    end else begin
      m_rd = m_cnt[hist_rd_addr];
      if (hist_clear) begin
        foreach (m_cnt[p]) m_cnt[p] = 0;
      end else if (m_valid && out_ready && m_cnt[m_part] != 32'hFFFF_FFFF) begin
        m_cnt[m_part] = m_cnt[m_part] + 1;
      end
    end
`endif
    if (reset) begin
      m_valid = 0; m_tuple = '0; m_part = '0; m_lane = 0; m_rr = 0;
    end else if (er != 0) begin
      m_valid = 1; m_tuple = ld_tuple; m_part = ld_tag[PB-1:0]; m_lane = g;
      m_rr = (g + 1) % 8;
    end else if (free) begin
      m_valid = 0;
    end
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_tuple", out_tuple, m_tuple);
    chk("out_part_id", 64'(out_part_id), 64'(m_part));
    chk("out_lane", 64'(out_lane), 64'(m_lane));
`ifdef HASH_LANE_HISTOGRAM_EN
    chk("hist_rd_data", 64'(hist_rd_data), 64'(m_rd));
`endif
  endtask

  initial begin
    logic [63:0] hold;
    reset = 1'b1; in_valid = '0; out_ready = 1'b1;
`ifdef HASH_LANE_HISTOGRAM_EN
    hist_clear = 1'b0;
`endif
    repeat (2) cycle();
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;

    // All lanes valid: lanes 0..7 then 0 again, one per cycle.
    in_valid = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      cycle();
      chk("rr_sequence_lane", 64'(out_lane), 64'(k % 8));
    end

    // Pointer now at 1: lanes 7 and 0 only, expect wrap.
    in_valid = 8'b1000_0001;
    cycle();
    chk("wrap_lane7", 64'(out_lane), 64'd7);
    cycle();
    chk("wrap_lane0", 64'(out_lane), 64'd0);
    in_valid = 8'hFF;
    #1;
    chk("after_wrap_grant1", 64'(ready_4_output), 64'h02);
    cycle();

    // Stall for 5 cycles, then release.
    out_ready = 1'b0;
    hold = out_tuple;
    repeat (5) begin
      cycle();
      chk("stall_tuple_stable", out_tuple, hold);
    end
    out_ready = 1'b1;
    #1;
    chk("resume_grant", 64'(|ready_4_output), 64'd1);
    cycle();

    // Partition index from low tag bits only.
    tag_fix = 32'hDEAD_BEE7;
    in_valid = 8'h10;
    cycle();
    chk("part_id_deadbee7", 64'(out_part_id), 64'h7);

`ifdef HASH_LANE_HISTOGRAM_EN
    in_valid = '0;
    repeat (2) cycle();
    hist_clear = 1'b1; cycle(); hist_clear = 1'b0;
    in_valid = 8'h01;
    repeat (3) cycle();
    in_valid = '0;
    rd_fix = 7;
    repeat (3) cycle();
    chk("hist_part7_count", 64'(hist_rd_data), 64'd3);
    // Clear concurrent with a transfer to partition 2 wins.
    tag_fix = 32'h0000_0002;
    in_valid = 8'h01;
    cycle();
    in_valid = '0;
    hist_clear = 1'b1; cycle(); hist_clear = 1'b0;
    rd_fix = 2;
    repeat (2) cycle();
    chk("hist_clear_wins", 64'(hist_rd_data), 64'd0);
    rd_fix = -1;
`endif
    tag_fix = '0;

    // Randomised traffic with back-pressure.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) == 0) ? 8'($urandom) & 8'($urandom) : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef HASH_LANE_HISTOGRAM_EN
      hist_clear = ($urandom_range(0, 49) == 0);
`endif
      cycle();
    end
`ifdef HASH_LANE_HISTOGRAM_EN
    hist_clear = 1'b0;
`endif

    // Reset while stalled drops the buffered tuple and rewinds the pointer.
    in_valid = 8'hFF; out_ready = 1'b1;
    cycle(); cycle();
    out_ready = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0; out_ready = 1'b1; in_valid = '0;
    cycle();
    chk("reset_stall_out_valid", 64'(out_valid), 64'd0);
    in_valid = 8'hFF;
    #1;
    chk("reset_stall_grant0", 64'(ready_4_output), 64'h01);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
